// File: rtl/uart_rx_word_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_word_ctrl
//
// Purpose:
//   Sits between the UART byte receiver and the core's input port/loader.
//   Received bytes are buffered in a small byte FIFO and then assembled into
//   32-bit big-endian words (mode_word=1) or single zero-extended bytes
//   (mode_word=0). Each word is offered on a valid/ready handshake. A byte
//   that arrives while the FIFO is full is dropped and the sticky overflow
//   flag is set.
//
// Optional feature (macro RX_TIMEOUT_EN):
//   Adds an idle counter. A partially gathered word (1..3 bytes) with an
//   empty FIFO is flushed after TIMEOUT_CYCLES idle cycles, zero-padded with
//   the received bytes left-aligned, and flagged with word_partial.
//
// Parameters:
//   DEPTH          byte FIFO depth (power of two, >= 4)
//   TIMEOUT_CYCLES idle cycles before a partial word is flushed
//                  (only present with RX_TIMEOUT_EN)
//
// Ports:
//   CLK           in   system clock
//   RST_N         in   synchronous reset, active low
//   byte_in       in   [7:0] received byte, qualified by byte_valid
//   byte_valid    in   one-cycle pulse per received byte
//   mode_word     in   1: four bytes per word, 0: one byte per word
//   word_out      out  [31:0] assembled word
//   word_valid    out  word_out holds a word
//   word_ready    in   consumer accepts word_out this cycle
//   level         out  [$clog2(DEPTH):0] bytes currently in the FIFO
//   overflow      out  sticky: a byte was dropped on a full FIFO
//   word_partial  out  current word_out was timeout-flushed (RX_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module uart_rx_word_ctrl #(
  parameter int DEPTH = 16
`ifdef RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 26040
`endif
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  input  logic                   mode_word,
  output logic [31:0]            word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef RX_TIMEOUT_EN
  ,
  output logic                   word_partial
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATHER,
    S_PRESENT
  } state_t;

  state_t        state_reg, state_next;

  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          overflow_reg, overflow_next;

  logic [2:0]    need_reg, need_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [31:0]   shift_reg, shift_next;
  logic [31:0]   word_reg, word_next;
  logic          valid_reg, valid_next;

  logic          push;
  logic          pop;
  logic [7:0]    rd_byte;

`ifdef RX_TIMEOUT_EN
  logic [31:0]   idle_reg, idle_next;
  logic          partial_reg, partial_next;
`endif

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  // Full is judged on the registered level only, so a pop in the same cycle
  // does not make room for an incoming byte.
  assign push = byte_valid && (level_reg != FULL_LEVEL);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= byte_in;
    end
  end

  // The popped byte is consumed in the same cycle it is popped, so the
  // (small) storage is read combinationally rather than through a read
  // register.
  assign rd_byte = mem_reg[rd_ptr_reg];

  always_comb begin
    level_next    = level_reg + LW'(push) - LW'(pop);
    overflow_next = overflow_reg | (byte_valid && (level_reg == FULL_LEVEL));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembly FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg   <= S_IDLE;
      need_reg    <= 3'd1;
      cnt_reg     <= 3'd0;
      shift_reg   <= '0;
      word_reg    <= '0;
      valid_reg   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_reg    <= '0;
      partial_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      need_reg    <= need_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      word_reg    <= word_next;
      valid_reg   <= valid_next;
`ifdef RX_TIMEOUT_EN
      idle_reg    <= idle_next;
      partial_reg <= partial_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembly FSM: next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    need_next    = need_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    word_next    = word_reg;
    valid_next   = valid_reg;
    pop          = 1'b0;
`ifdef RX_TIMEOUT_EN
    partial_next = partial_reg;
    // Idle time only accumulates while a word is partly gathered and
    // starved of bytes; any byte activity restarts it.
    idle_next    = idle_reg;
    if (byte_valid || (state_reg == S_GATHER && level_reg != '0)) begin
      idle_next = '0;
    end else if (state_reg == S_GATHER && cnt_reg != 3'd0) begin
      idle_next = idle_reg + 32'd1;
    end
`endif

    case (state_reg)
      S_IDLE: begin
        // mode_word is captured once per word here; later changes wait
        // for the next word.
        if (level_reg != '0) begin
          need_next  = mode_word ? 3'd4 : 3'd1;
          cnt_next   = 3'd0;
          shift_next = '0;
          state_next = S_GATHER;
        end
      end

      S_GATHER: begin
        if (level_reg != '0) begin
          pop        = 1'b1;
          shift_next = {shift_reg[23:0], rd_byte};
          cnt_next   = cnt_reg + 3'd1;
          // With a cleared shift register a single byte is already
          // zero-extended, so both modes present shift_next directly.
          if (cnt_next == need_reg) begin
            word_next  = shift_next;
            valid_next = 1'b1;
            state_next = S_PRESENT;
          end
        end
`ifdef RX_TIMEOUT_EN
        else if (!byte_valid && cnt_reg != 3'd0 &&
                 idle_reg == 32'(TIMEOUT_CYCLES - 1)) begin
          // Left-align the gathered bytes: shift out the missing lanes.
          word_next    = shift_reg << (6'd32 - {cnt_reg, 3'b000});
          valid_next   = 1'b1;
          partial_next = 1'b1;
          idle_next    = '0;
          state_next   = S_PRESENT;
        end
`endif
      end

      S_PRESENT: begin
        if (word_ready) begin
          valid_next = 1'b0;
`ifdef RX_TIMEOUT_EN
          partial_next = 1'b0;
`endif
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign word_out     = word_reg;
  assign word_valid   = valid_reg;
  assign level        = level_reg;
  assign overflow     = overflow_reg;
`ifdef RX_TIMEOUT_EN
  assign word_partial = partial_reg;
`endif

endmodule
